// File: rtl/dfi_init_pkg.sv
// Shared types for the DDR3 initialisation sequencer: FSM states, DFI command
// encodings and small elaboration helpers.
package dfi_init_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_PHY,
        ST_RESET,
        ST_CKE_WAIT,
        ST_XPR,
        ST_MRS2,
        ST_MRS3,
        ST_MRS1,
        ST_MRS0,
        ST_ZQCL,
        ST_DONE
    } init_state_e;

    typedef struct packed {
        logic ras_n;
        logic cas_n;
        logic we_n;
    } cmd_t;

    localparam cmd_t CMD_NOP  = '{ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1};
    localparam cmd_t CMD_MRS  = '{ras_n: 1'b0, cas_n: 1'b0, we_n: 1'b0};
    localparam cmd_t CMD_ZQCL = '{ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b0};

    // A10 selects the long ZQ calibration variant.
    localparam int ZQCL_ADDR_BIT = 10;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/init_timer.sv
// Loadable down-counter pacing each timed state of the init sequencer.
// Loading T-1 on entry and advancing when zero gives exactly T cycles.
module init_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/dfi_init_seq.sv
// DDR3 power-up sequencer: RESET#/CKE bring-up, MR2/MR3/MR1/MR0 programming,
// ZQCL, then init_done with NOP forever. Outputs are registered from the next state.
module dfi_init_seq
    import dfi_init_pkg::*;
#(
    parameter int          ADDR_W       = 16,
    parameter int          BANK_W       = 3,
    parameter int          CS_W         = 1,
    parameter int unsigned T_RESET_CYC  = 80000,
    parameter int unsigned T_CKE_CYC    = 200000,
    parameter int unsigned T_XPR_CYC    = 64,
    parameter int unsigned T_MRD_CYC    = 4,
    parameter int unsigned T_MOD_CYC    = 12,
    parameter int unsigned T_ZQINIT_CYC = 512,
    parameter logic [15:0] MR0          = 16'h0,
    parameter logic [15:0] MR1          = 16'h0,
    parameter logic [15:0] MR2          = 16'h0,
    parameter logic [15:0] MR3          = 16'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              phy_init_complete,
    output logic              init_done,
    output logic [ADDR_W-1:0] dfi_address,
    output logic [BANK_W-1:0] dfi_bank,
    output logic              dfi_ras_n,
    output logic              dfi_cas_n,
    output logic              dfi_we_n,
    output logic [CS_W-1:0]   dfi_cs_n,
    output logic [CS_W-1:0]   dfi_cke,
    output logic [CS_W-1:0]   dfi_odt,
    output logic              dfi_reset_n,
    output logic              dfi_dram_clk_disable
);

    localparam int unsigned T_MAX = max_u(max_u(max_u(T_RESET_CYC, T_CKE_CYC),
                                                max_u(T_XPR_CYC, T_MRD_CYC)),
                                          max_u(T_MOD_CYC, T_ZQINIT_CYC));
    localparam int CNT_W = $clog2(T_MAX + 1);

    if ((T_RESET_CYC < 1) || (T_CKE_CYC < 1) || (T_XPR_CYC < 1) ||
        (T_MRD_CYC < 1) || (T_MOD_CYC < 1) || (T_ZQINIT_CYC < 1)) begin : g_bad_timing
        $error("dfi_init_seq: every T_*_CYC parameter must be >= 1");
    end
    if ((ADDR_W <= ZQCL_ADDR_BIT) || (BANK_W < 2)) begin : g_bad_width
        $error("dfi_init_seq: ADDR_W must exceed 10 and BANK_W must be >= 2");
    end

    init_state_e      state, state_next;
    logic             tmr_load, tmr_zero;
    logic [CNT_W-1:0] tmr_value;

    logic              done_next;
    logic [ADDR_W-1:0] addr_next;
    logic [BANK_W-1:0] bank_next;
    cmd_t              cmd_next, cmd_q;
    logic [CS_W-1:0]   cs_next, cke_next;
    logic              rstn_next, clkdis_next;

    function automatic logic [CNT_W-1:0] load_for(input init_state_e s);
        case (s)
            ST_RESET:    return CNT_W'(T_RESET_CYC - 1);
            ST_CKE_WAIT: return CNT_W'(T_CKE_CYC - 1);
            ST_XPR:      return CNT_W'(T_XPR_CYC - 1);
            ST_MRS2,
            ST_MRS3,
            ST_MRS1:     return CNT_W'(T_MRD_CYC - 1);
            ST_MRS0:     return CNT_W'(T_MOD_CYC - 1);
            ST_ZQCL:     return CNT_W'(T_ZQINIT_CYC - 1);
            default:     return '0;
        endcase
    endfunction

    init_timer #(.W(CNT_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .value (tmr_value),
        .zero  (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first, otherwise an unassigned path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (start)             state_next = ST_WAIT_PHY;
            ST_WAIT_PHY: if (phy_init_complete) state_next = ST_RESET;
            ST_RESET:    if (tmr_zero)          state_next = ST_CKE_WAIT;
            ST_CKE_WAIT: if (tmr_zero)          state_next = ST_XPR;
            ST_XPR:      if (tmr_zero)          state_next = ST_MRS2;
            ST_MRS2:     if (tmr_zero)          state_next = ST_MRS3;
            ST_MRS3:     if (tmr_zero)          state_next = ST_MRS1;
            ST_MRS1:     if (tmr_zero)          state_next = ST_MRS0;
            ST_MRS0:     if (tmr_zero)          state_next = ST_ZQCL;
            ST_ZQCL:     if (tmr_zero)          state_next = ST_DONE;
            ST_DONE:                            state_next = ST_DONE;
            default:                            state_next = ST_IDLE;
        endcase
    end

    assign tmr_load  = (state_next != state);
    assign tmr_value = load_for(state_next);

    // Decode from the next state so the registered outputs line up with the state register;
    // a command is issued only on the entry cycle of MRS/ZQCL states.
    always_comb begin
        done_next   = 1'b0;
        addr_next   = '0;
        bank_next   = '0;
        cmd_next    = CMD_NOP;
        cs_next     = '1;
        cke_next    = '0;
        rstn_next   = 1'b0;
        clkdis_next = 1'b1;

        case (state_next)
            ST_IDLE, ST_WAIT_PHY, ST_RESET: ;
            ST_CKE_WAIT: begin
                rstn_next   = 1'b1;
                clkdis_next = 1'b0;
            end
            default: begin
                rstn_next   = 1'b1;
                clkdis_next = 1'b0;
                cke_next    = '1;
                cs_next     = '0;
            end
        endcase

        if (tmr_load) begin
            case (state_next)
                ST_MRS2: begin cmd_next = CMD_MRS; bank_next = BANK_W'(2); addr_next = ADDR_W'(MR2); end
                ST_MRS3: begin cmd_next = CMD_MRS; bank_next = BANK_W'(3); addr_next = ADDR_W'(MR3); end
                ST_MRS1: begin cmd_next = CMD_MRS; bank_next = BANK_W'(1); addr_next = ADDR_W'(MR1); end
                ST_MRS0: begin cmd_next = CMD_MRS; bank_next = BANK_W'(0); addr_next = ADDR_W'(MR0); end
                ST_ZQCL: begin
                    cmd_next                 = CMD_ZQCL;
                    addr_next[ZQCL_ADDR_BIT] = 1'b1;
                end
                default: ;
            endcase
        end

        done_next = (state_next == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done            <= 1'b0;
            dfi_address          <= '0;
            dfi_bank             <= '0;
            cmd_q                <= CMD_NOP;
            dfi_cs_n             <= '1;
            dfi_cke              <= '0;
            dfi_reset_n          <= 1'b0;
            dfi_dram_clk_disable <= 1'b1;
        end else begin
            init_done            <= done_next;
            dfi_address          <= addr_next;
            dfi_bank             <= bank_next;
            cmd_q                <= cmd_next;
            dfi_cs_n             <= cs_next;
            dfi_cke              <= cke_next;
            dfi_reset_n          <= rstn_next;
            dfi_dram_clk_disable <= clkdis_next;
        end
    end

    assign dfi_ras_n = cmd_q.ras_n;
    assign dfi_cas_n = cmd_q.cas_n;
    assign dfi_we_n  = cmd_q.we_n;
    assign dfi_odt   = '0;

endmodule

// File: tb/tb_dfi_init_seq.sv
// Bench for dfi_init_seq: cycle-accurate behavioural model (sequence offset arithmetic)
// compared every cycle, plus directed timing/command-log pins and randomized stimulus.
module tb_dfi_init_seq;

    localparam int          ADDR_W = 16;
    localparam int          BANK_W = 3;
    localparam int          CS_W   = 2;
    localparam int          T_RST  = 4;
    localparam int          T_CKE  = 6;
    localparam int          T_XPR  = 3;
    localparam int          T_MRD  = 4;
    localparam int          T_MOD  = 5;
    localparam int          T_ZQ   = 8;
    localparam logic [15:0] MR0    = 16'h1220;
    localparam logic [15:0] MR1    = 16'h0044;
    localparam logic [15:0] MR2    = 16'h0018;
    localparam logic [15:0] MR3    = 16'h0000;

    // Offsets (cycles after RESET entry) at which each phase begins.
    localparam int B1 = T_RST;
    localparam int B2 = B1 + T_CKE;
    localparam int B3 = B2 + T_XPR;
    localparam int B4 = B3 + T_MRD;
    localparam int B5 = B4 + T_MRD;
    localparam int B6 = B5 + T_MRD;
    localparam int B7 = B6 + T_MOD;
    localparam int B8 = B7 + T_ZQ;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start = 1'b0;
    logic              phy_init_complete = 1'b0;
    logic              init_done;
    logic [ADDR_W-1:0] dfi_address;
    logic [BANK_W-1:0] dfi_bank;
    logic              dfi_ras_n, dfi_cas_n, dfi_we_n;
    logic [CS_W-1:0]   dfi_cs_n, dfi_cke, dfi_odt;
    logic              dfi_reset_n, dfi_dram_clk_disable;

    dfi_init_seq #(
        .ADDR_W(ADDR_W), .BANK_W(BANK_W), .CS_W(CS_W),
        .T_RESET_CYC(T_RST), .T_CKE_CYC(T_CKE), .T_XPR_CYC(T_XPR),
        .T_MRD_CYC(T_MRD), .T_MOD_CYC(T_MOD), .T_ZQINIT_CYC(T_ZQ),
        .MR0(MR0), .MR1(MR1), .MR2(MR2), .MR3(MR3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .phy_init_complete(phy_init_complete),
        .init_done(init_done), .dfi_address(dfi_address), .dfi_bank(dfi_bank),
        .dfi_ras_n(dfi_ras_n), .dfi_cas_n(dfi_cas_n), .dfi_we_n(dfi_we_n),
        .dfi_cs_n(dfi_cs_n), .dfi_cke(dfi_cke), .dfi_odt(dfi_odt),
        .dfi_reset_n(dfi_reset_n), .dfi_dram_clk_disable(dfi_dram_clk_disable)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: 0 = idle, 1 = waiting for PHY, 2 = running with offset rc.
    int mode = 0;
    int rc   = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= 0;
            rc   <= 0;
        end else begin
            case (mode)
                0: if (start) mode <= 1;
                1: if (phy_init_complete) begin mode <= 2; rc <= 0; end
                default: if (rc < B8) rc <= rc + 1;
            endcase
        end
    end

    function automatic logic [30:0] expect_vec(input int m, input int r);
        logic        d   = 1'b0;
        logic [15:0] a   = '0;
        logic [2:0]  b   = '0;
        logic [2:0]  c   = 3'b111;
        logic [1:0]  cs  = 2'b11;
        logic [1:0]  ck  = 2'b00;
        logic        rn  = 1'b0;
        logic        dcd = 1'b1;
        if (m == 2) begin
            if (r >= B1) begin rn = 1'b1; dcd = 1'b0; end
            if (r >= B2) begin ck = 2'b11; cs = 2'b00; end
            if (r == B3) begin c = 3'b000; b = 3'd2; a = MR2; end
            if (r == B4) begin c = 3'b000; b = 3'd3; a = MR3; end
            if (r == B5) begin c = 3'b000; b = 3'd1; a = MR1; end
            if (r == B6) begin c = 3'b000; b = 3'd0; a = MR0; end
            if (r == B7) begin c = 3'b110; a = 16'h0400; end
            if (r >= B8) d = 1'b1;
        end
        return {d, a, b, c, cs, ck, 2'b00, rn, dcd};
    endfunction

    logic [30:0] act_vec, exp_vec;
    assign act_vec = {init_done, dfi_address, dfi_bank, dfi_ras_n, dfi_cas_n, dfi_we_n,
                      dfi_cs_n, dfi_cke, dfi_odt, dfi_reset_n, dfi_dram_clk_disable};

    always @(negedge clk) begin
        exp_vec = expect_vec(mode, rc);
        vectors++;
        if (act_vec !== exp_vec) begin
            miscompares++;
            $display("FAIL outputs cycle %0d: got %b, expected %b", cyc, act_vec, exp_vec);
        end
    end

    // Event log sampled just after each active edge.
    typedef struct {
        int          c;
        logic [2:0]  op;
        logic [2:0]  b;
        logic [15:0] a;
    } cmd_rec_t;

    cmd_rec_t cmds[$];
    int rn_rise = -1, cke_rise = -1, dcd_fall = -1, done_rise = -1;
    logic prev_rn = 1'b0, prev_cke = 1'b0, prev_dcd = 1'b1, prev_done = 1'b0;

    always @(posedge clk) begin
        #1;
        if (dfi_reset_n && !prev_rn)            rn_rise   = cyc;
        if (dfi_cke[0] && !prev_cke)            cke_rise  = cyc;
        if (!dfi_dram_clk_disable && prev_dcd)  dcd_fall  = cyc;
        if (init_done && !prev_done)            done_rise = cyc;
        if ({dfi_ras_n, dfi_cas_n, dfi_we_n} != 3'b111)
            cmds.push_back('{c: cyc, op: {dfi_ras_n, dfi_cas_n, dfi_we_n}, b: dfi_bank, a: dfi_address});
        prev_rn   = dfi_reset_n;
        prev_cke  = dfi_cke[0];
        prev_dcd  = dfi_dram_clk_disable;
        prev_done = init_done;
    end

    task automatic clear_log();
        cmds.delete();
        rn_rise = -1; cke_rise = -1; dcd_fall = -1; done_rise = -1;
    endtask

    task automatic reset_pulse();
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && done_rise < 0; i++) @(negedge clk);
        check("done_seen", done_rise >= 0, 1);
    endtask

    task automatic check_log();
        int eb[5]  = '{2, 3, 1, 0, 0};
        int ea[5]  = '{16'h0018, 16'h0000, 16'h0044, 16'h1220, 16'h0400};
        int eo[5]  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b110};
        int gap[5] = '{9, 4, 4, 4, 5};
        check("cke_after_reset_n", cke_rise - rn_rise, 6);
        check("done_after_reset_n", done_rise - rn_rise, 34);
        check("clk_enable_at_cke_wait", dcd_fall, rn_rise);
        check("cmd_count", cmds.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < cmds.size()) begin
                check($sformatf("cmd%0d_op", k), cmds[k].op, eo[k]);
                check($sformatf("cmd%0d_bank", k), cmds[k].b, eb[k]);
                check($sformatf("cmd%0d_addr", k), cmds[k].a, ea[k]);
                check($sformatf("cmd%0d_gap", k),
                      cmds[k].c - ((k == 0) ? rn_rise : cmds[k-1].c), gap[k]);
            end
        end
        if (cmds.size() == 5) check("done_after_zqcl", done_rise - cmds[4].c, 8);
    endtask

    task automatic run_directed(input bit repulse);
        int  start_cyc;
        bit  pulsed = 1'b0;
        clear_log();
        @(negedge clk); start = 1'b1; phy_init_complete = 1'b1; start_cyc = cyc;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 200 && done_rise < 0; i++) begin
            @(negedge clk);
            if (repulse && !pulsed && cke_rise >= 0) begin start = 1'b1; pulsed = 1'b1; end
            else start = 1'b0;
        end
        start = 1'b0;
        check("done_seen", done_rise >= 0, 1);
        if (repulse) begin
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
        end
        repeat (10) @(negedge clk);
        check("init_done_sticky", init_done, 1);
        check("reset_phase_len", rn_rise - start_cyc, 6);
        check_log();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int abort_at, phy_cyc;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_reset_n", dfi_reset_n, 0);
        check("reset_cs_n", dfi_cs_n, 2'b11);
        check("reset_clk_disable", dfi_dram_clk_disable, 1);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal run, then with start re-pulsed during XPR and DONE.
        run_directed(1'b0);
        reset_pulse();
        run_directed(1'b1);

        // PHY not ready for 20 cycles after start.
        reset_pulse();
        clear_log();
        @(negedge clk); phy_init_complete = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (20) @(negedge clk);
        check("phy_wait_reset_n", dfi_reset_n, 0);
        check("phy_wait_cke", dfi_cke, 0);
        phy_init_complete = 1'b1; phy_cyc = cyc;
        wait_done();
        check("phy_to_reset_n", rn_rise - phy_cyc, 5);
        check("phy_done_after_reset_n", done_rise - rn_rise, 34);

        // Async reset in the middle of MRS1, then a full replay.
        reset_pulse();
        clear_log();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 100 && cmds.size() < 3; i++) @(negedge clk);
        check("reached_mrs1", cmds.size() >= 3, 1);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("abort_reset_n", dfi_reset_n, 0);
        check("abort_cke", dfi_cke, 0);
        check("abort_cs_n", dfi_cs_n, 2'b11);
        check("abort_done", init_done, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        run_directed(1'b0);

        // Randomized start/PHY activity with occasional mid-sequence reset.
        for (int it = 0; it < 25; it++) begin
            reset_pulse();
            abort_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(5, 60)) : -1;
            for (int c = 0; c < 120; c++) begin
                @(negedge clk);
                start             = ($urandom_range(0, 5) == 0);
                phy_init_complete = ($urandom_range(0, 2) != 0);
                if (c == abort_at) reset_pulse();
            end
            start = 1'b0;
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
